// File: rtl/aes_128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_pkg
// Description : Shared sizes, state encoding and key-index helper for the
//               AES-128 controller and its round-key table.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_128_pkg;

   localparam int AES_NKEYS  = 11;
   localparam int AES_BLK_W  = 128;
   localparam int AES_KIDX_W = 4;

   // Last valid round-key index (round key 10)
   localparam logic [AES_KIDX_W-1:0] c_kidx_last = AES_KIDX_W'(AES_NKEYS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } ctrl_state_t;

   // Next round-key index, holding at the last key so extra key_ready pulses
   // keep re-presenting round key 10
   function automatic logic [AES_KIDX_W-1:0] kidx_next(input logic [AES_KIDX_W-1:0] idx);
      return (idx >= c_kidx_last) ? c_kidx_last : idx + AES_KIDX_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_128_key_table.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_key_table
// Description : Round-key register file (NKEYS x 128) with a write port,
//               per-entry valid mask, all-loaded flag and async read port.
//               Key contents are not reset; only the valid mask is.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_key_table
   import aes_128_pkg::*;
#(
   parameter int NKEYS = AES_NKEYS
) (
   input  logic                  clk,
   input  logic                  kill,
   input  logic                  wr_en,
   input  logic [AES_KIDX_W-1:0] wr_addr,
   input  logic [AES_BLK_W-1:0]  wr_data,
   input  logic [AES_KIDX_W-1:0] rd_addr,
   output logic [AES_BLK_W-1:0]  rd_data,
   output logic                  keys_loaded
);

   logic [AES_BLK_W-1:0] r_mem [NKEYS];
   logic [NKEYS-1:0]     r_valid;
   logic [NKEYS-1:0]     w_dec;

   // One-hot write decode; out-of-range addresses hit no entry
   generate
      for (genvar gi = 0; gi < NKEYS; gi++) begin : g_dec
         assign w_dec[gi] = wr_en && (wr_addr == AES_KIDX_W'(gi));
      end
   endgenerate

   // Key storage: plain registers, deliberately left out of reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < NKEYS; i++) begin
         if (w_dec[i]) begin
            r_mem[i] <= wr_data;
         end
      end
   end

   // Valid mask: set by a write, cleared only by kill
   always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
         r_valid <= '0;
      end else begin
         r_valid <= r_valid | w_dec;
      end
   end

   assign rd_data     = (rd_addr < AES_KIDX_W'(NKEYS)) ? r_mem[rd_addr] : '0;
   assign keys_loaded = &r_valid;

endmodule
`default_nettype wire

// File: rtl/aes_128_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_ctrl
// Description : Front-end controller for the AES-128 core. Holds the round-key
//               table, arbitrates two requesters round-robin, issues one block
//               at a time, streams round keys on key_ready, returns the tagged
//               result and abandons blocks that exceed TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_ctrl
   import aes_128_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int NKEYS   = AES_NKEYS
) (
   input  logic                  clk,
   input  logic                  kill,
   // round-key table write port
   input  logic                  key_wr_en,
   input  logic [AES_KIDX_W-1:0] key_wr_addr,
   input  logic [AES_BLK_W-1:0]  key_wr_data,
   output logic                  key_wr_err,
   // requesters
   input  logic                  req0_valid,
   input  logic [AES_BLK_W-1:0]  req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [AES_BLK_W-1:0]  req1_data,
   output logic                  req1_ready,
   // response
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [AES_BLK_W-1:0]  rsp_data,
   output logic                  err_timeout,
   // core interface
   output logic                  in_en,
   output logic [AES_BLK_W-1:0]  in_data,
   output logic [AES_BLK_W-1:0]  key_round,
   input  logic                  key_ready,
   input  logic                  out_en,
   input  logic [AES_BLK_W-1:0]  out_data
);

   localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

   ctrl_state_t           r_state;
   ctrl_state_t           w_state_nxt;

   logic                  r_last_grant;
   logic                  r_id;
   logic [AES_KIDX_W-1:0] r_kidx;
   logic [c_cnt_w-1:0]    r_cnt;
   logic                  r_in_en;
   logic [AES_BLK_W-1:0]  r_in_data;
   logic [AES_BLK_W-1:0]  r_key_round;
   logic [AES_BLK_W-1:0]  r_rsp_data;
   logic                  r_key_wr_err;
   logic                  r_err_timeout;

   logic                  w_accept;
   logic                  w_grant;
   logic                  w_timeout;
   logic                  w_key_wr_ok;
   logic                  w_keys_loaded;
   logic [AES_KIDX_W-1:0] w_rd_addr;
   logic [AES_BLK_W-1:0]  w_rd_data;

   // Table writes are only honoured while idle and in range
   assign w_key_wr_ok = key_wr_en && (r_state == ST_IDLE) && (key_wr_addr <= c_kidx_last);

   // Outside RUN the read port always looks at round key 0
   assign w_rd_addr = (r_state == ST_RUN) ? r_kidx : '0;

   aes_128_key_table #(
      .NKEYS       (NKEYS)
   ) u_key_table (
      .clk         (clk),
      .kill        (kill),
      .wr_en       (w_key_wr_ok),
      .wr_addr     (key_wr_addr),
      .wr_data     (key_wr_data),
      .rd_addr     (w_rd_addr),
      .rd_data     (w_rd_data),
      .keys_loaded (w_keys_loaded)
   );

   // State register
   always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, arbitration and combinational outputs
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_grant     = 1'b0;
      w_timeout   = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp_valid   = 1'b0;
      rsp_id      = 1'b0;
      rsp_data    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_keys_loaded && (req0_valid || req1_valid)) begin
               w_accept    = 1'b1;
               // with both asking, the one not served last wins
               w_grant     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
               req0_ready  = ~w_grant;
               req1_ready  = w_grant;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // a result arriving on the timeout cycle still counts
            if (out_en) begin
               w_state_nxt = ST_RESP;
            end else if (r_cnt == c_cnt_last) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RESP: begin
            rsp_valid   = 1'b1;
            rsp_id      = r_id;
            rsp_data    = r_rsp_data;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Block datapath: launch, round-key stepping, timeout count, result capture
   always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_kidx       <= AES_KIDX_W'(1);
         r_cnt        <= '0;
         r_in_en      <= 1'b0;
         r_in_data    <= '0;
         r_key_round  <= '0;
         r_rsp_data   <= '0;
      end else begin
         r_in_en   <= 1'b0;
         r_in_data <= '0;
         case (r_state)
            ST_IDLE: begin
               r_key_round <= w_rd_data;
               if (w_accept) begin
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  r_kidx       <= AES_KIDX_W'(1);
                  r_cnt        <= '0;
                  r_in_en      <= 1'b1;
                  r_in_data    <= w_grant ? req1_data : req0_data;
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + c_cnt_w'(1);
               if (key_ready) begin
                  r_key_round <= w_rd_data;
                  r_kidx      <= kidx_next(r_kidx);
               end
               if (out_en) begin
                  r_rsp_data <= out_data;
               end
            end
            ST_RESP: begin
               r_key_round <= w_rd_data;
               r_kidx      <= AES_KIDX_W'(1);
            end
            default: begin
               r_kidx <= AES_KIDX_W'(1);
            end
         endcase
      end
   end

   // One-cycle error pulses, delayed one cycle from their cause
   always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
         r_key_wr_err  <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_key_wr_err  <= key_wr_en && !w_key_wr_ok;
         r_err_timeout <= w_timeout;
      end
   end

   assign key_wr_err  = r_key_wr_err;
   assign err_timeout = r_err_timeout;
   assign in_en       = r_in_en;
   assign in_data     = r_in_data;
   assign key_round   = r_key_round;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_ctrl
// Description : Self-checking bench for aes_128_ctrl with a behavioural core
//               stub and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_ctrl;

   localparam int TIMEOUT = 64;

   localparam logic [127:0] FIPS_PT = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] FIPS_CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   // FIPS-197 round keys in document byte order, index 10 first
   localparam logic [10:0][127:0] FIPS_RK = {
      128'h13111d7fe3944a17f307a78b4d2b30c5,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h47438735a41c65b9e016baf4aebf7ad2,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'h000102030405060708090a0b0c0d0e0f
   };

   logic         clk = 1'b0;
   logic         kill;
   logic         key_wr_en;
   logic [3:0]   key_wr_addr;
   logic [127:0] key_wr_data;
   logic         key_wr_err;
   logic         req0_valid, req1_valid;
   logic [127:0] req0_data, req1_data;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id;
   logic [127:0] rsp_data;
   logic         err_timeout;
   logic         in_en;
   logic [127:0] in_data, key_round;
   logic         key_ready, out_en;
   logic [127:0] out_data;

   aes_128_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .kill        (kill),
      .key_wr_en   (key_wr_en),
      .key_wr_addr (key_wr_addr),
      .key_wr_data (key_wr_data),
      .key_wr_err  (key_wr_err),
      .req0_valid  (req0_valid),
      .req0_data   (req0_data),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_data   (req1_data),
      .req1_ready  (req1_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .err_timeout (err_timeout),
      .in_en       (in_en),
      .in_data     (in_data),
      .key_round   (key_round),
      .key_ready   (key_ready),
      .out_en      (out_en),
      .out_data    (out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic         id;
      logic [127:0] data;
   } rsp_t;

   rsp_t              sb[$];
   logic [10:0][127:0] m_tab;
   logic [10:0][127:0] fips_k;
   int                n_tests = 0;
   int                n_fail  = 0;
   int                n_kerr  = 0;
   int                n_terr  = 0;
   int                t_err   = 0;
   int                t_in_en = 0;
   bit                stub_silent = 1'b0;
   bit                stub_extra  = 1'b0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] bswap(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = v[(15-i)*8 +: 8];
      return r;
   endfunction

   // Stand-in for the cipher: the FIPS vector maps to its known ciphertext,
   // anything else to a keyed fold that depends on every round key received
   function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [10:0][127:0] k);
      logic [127:0] acc;
      if (pt == FIPS_PT && k == fips_k) return FIPS_CT;
      acc = pt;
      for (int r = 0; r < 11; r++) acc = {acc[126:0], acc[127]} ^ k[r];
      return acc;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {key_wr_err, req0_ready, req1_ready, rsp_valid, rsp_id, err_timeout, in_en}, '0);
      check({tag, "_rsp_data"}, rsp_data, '0);
      check({tag, "_in_data"}, in_data, '0);
      check({tag, "_key_round"}, key_round, '0);
   endtask

   task automatic wr_key(input logic [3:0] a, input logic [127:0] d, input bit upd);
      @(posedge clk); #1;
      key_wr_en = 1'b1; key_wr_addr = a; key_wr_data = d;
      @(posedge clk); #1;
      key_wr_en = 1'b0;
      if (upd) m_tab[a] = d;
   endtask

   task automatic push_exp(input logic id, input logic [127:0] d);
      rsp_t e;
      e.id   = id;
      e.data = core_fn(d, m_tab);
      sb.push_back(e);
   endtask

   task automatic send(input bit id, input logic [127:0] d, input bit exp_rsp, input int budget);
      bit got = 1'b0;
      @(posedge clk); #1;
      if (id) begin req1_valid = 1'b1; req1_data = d; end
      else    begin req0_valid = 1'b1; req0_data = d; end
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            got = 1'b1;
            if (exp_rsp) push_exp(id, d);
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("accept", got, 1'b1);
   endtask

   // Holds req0 valid for n cycles; nothing may be accepted or launched
   task automatic probe_no_accept(input string tag, input int n);
      bit seen = 1'b0;
      req0_valid = 1'b1;
      req0_data  = FIPS_PT;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (req0_ready || in_en) seen = 1'b1;
         @(posedge clk); #1;
      end
      check(tag, seen, 1'b0);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int i = 0;
      while (sb.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(tag, sb.size(), 0);
   endtask

   // Core stub: takes the block, pulses key_ready per round, returns out_data
   initial begin : core_stub
      bit ok;
      logic [10:0][127:0] stub_k;
      logic [127:0] stub_pt;
      key_ready = 1'b0; out_en = 1'b0; out_data = '0;
      forever begin
         @(negedge clk);
         if (in_en && !kill) begin
            t_in_en   = cyc;
            stub_pt   = in_data;
            stub_k    = '0;
            stub_k[0] = key_round;
            check("kr0", key_round, m_tab[0]);
            if (!stub_silent) begin
               ok = 1'b1;
               for (int r = 1; r <= 10 + (stub_extra ? 1 : 0) && ok; r++) begin
                  @(posedge clk); #1 key_ready = 1'b1;
                  @(posedge clk); #1 key_ready = 1'b0;
                  @(negedge clk);
                  if (kill) ok = 1'b0;
                  else begin
                     if (r == 1) begin
                        check("in_en_pulse", in_en, 1'b0);
                        check("in_data_clr", in_data, '0);
                     end
                     if (r <= 10) begin
                        stub_k[r] = key_round;
                        check("kr_step", key_round, m_tab[r]);
                     end else begin
                        check("kr_sat", key_round, m_tab[10]);
                     end
                  end
               end
               if (ok) begin
                  @(posedge clk); #1 out_en = 1'b1; out_data = core_fn(stub_pt, stub_k);
                  @(posedge clk); #1 out_en = 1'b0; out_data = '0;
               end
            end
         end
      end
   end

   // Response scoreboard and pulse counters
   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!kill) begin
            if (rsp_valid) begin
               if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
               else begin
                  e = sb.pop_front();
                  check("rsp_id", rsp_id, e.id);
                  check("rsp_data", rsp_data, e.data);
               end
            end
            if (key_wr_err) n_kerr++;
            if (err_timeout) begin n_terr++; t_err = cyc; end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int kerr0, terr0, ng, i;
      logic gid;
      kill = 1'b1;
      key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
      m_tab = '0;
      for (int k = 0; k < 11; k++) fips_k[k] = bswap(FIPS_RK[k]);

      // reset state
      repeat (2) @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1 kill = 1'b0;

      // partial key table blocks acceptance; 11th key enables it next cycle
      for (int k = 0; k < 10; k++) wr_key(4'(k), fips_k[k], 1'b1);
      probe_no_accept("no_accept_10_keys", 6);
      key_wr_en = 1'b1; key_wr_addr = 4'd10; key_wr_data = fips_k[10];
      m_tab[10] = fips_k[10];
      @(posedge clk); #1 key_wr_en = 1'b0;
      @(negedge clk);
      check("ready_T", req0_ready, 1'b1);
      if (req0_ready) push_exp(1'b0, FIPS_PT);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      check("in_en_T1", in_en, 1'b1);
      check("in_data_T1", in_data, FIPS_PT);
      check("key_round_T1", key_round, fips_k[0]);
      wait_drain("fips_rsp", 100);

      // dropped writes: during RUN and out of range; extra key_ready saturates
      kerr0 = n_kerr;
      stub_extra = 1'b1;
      send(1'b0, 128'h0123456789abcdef0011223344556677, 1'b1, 10);
      repeat (3) @(posedge clk);
      wr_key(4'd3, ~fips_k[3], 1'b0);
      wait_drain("run_write_rsp", 100);
      stub_extra = 1'b0;
      wr_key(4'd12, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0);
      repeat (2) @(negedge clk);
      check("key_wr_err_cnt", n_kerr - kerr0, 2);

      // core never answers: timeout after TIMEOUT cycles, then recovery
      terr0 = n_terr;
      stub_silent = 1'b1;
      send(1'b1, 128'h00000000111111112222222233333333, 1'b0, 10);
      i = 0;
      while (n_terr == terr0 && i < 200) begin @(negedge clk); i++; end
      check("timeout_cnt", n_terr - terr0, 1);
      check("timeout_latency", t_err - t_in_en, TIMEOUT);
      stub_silent = 1'b0;
      send(1'b0, 128'hcafef00dcafef00dcafef00dcafef00d, 1'b1, 5);
      wait_drain("after_timeout_rsp", 100);

      // kill mid-RUN: outputs clear, mask clears, block is lost
      send(1'b0, FIPS_PT, 1'b1, 5);
      repeat (6) @(posedge clk);
      #1 kill = 1'b1;
      @(negedge clk);
      check_zero("kill_a");
      @(negedge clk);
      check_zero("kill_b");
      @(posedge clk); #1 kill = 1'b0;
      sb.delete();
      probe_no_accept("no_accept_after_kill", 5);
      req0_valid = 1'b0;
      for (int k = 0; k < 11; k++) wr_key(4'(k), fips_k[k], 1'b1);

      // both requesters continuously valid: 0, 1, 0 (first is the FIPS rerun)
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_data = FIPS_PT;
      req1_valid = 1'b1; req1_data = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;
      ng = 0; i = 0;
      while (ng < 3 && i < 300) begin
         @(negedge clk);
         i++;
         if (req0_ready || req1_ready) begin
            gid = req1_ready;
            check("grant_onehot", req0_ready & req1_ready, 1'b0);
            check("grant_order", gid, (ng == 1));
            push_exp(gid, gid ? req1_data : req0_data);
            ng++;
         end
      end
      check("grant_count", ng, 3);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_drain("rr_rsp", 150);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_128_ctrl.md
Name: aes_128_ctrl

Overview:
Controller in front of the 128-bit AES core. It holds the 11-entry round-key table and arbitrates two block requesters round-robin. It issues one block at a time to the core and feeds round keys on each key_ready pulse. It returns the core result to the requester that owns it, tagged with that requester's id. Byte order matches the core: byte 0 sits in bits [7:0].

Parameters:
TIMEOUT, 64, max cycles from in_en to out_en before the block is abandoned
NKEYS, 11, round-key table depth (round keys 0..10); fixed for AES-128

Ports:
clk  in  1  clock, rising edge
kill  in  1  asynchronous active-high reset
key_wr_en  in  1  round-key table write strobe
key_wr_addr  in  4  table index 0..10
key_wr_data  in  128  round key
key_wr_err  out  1  one-cycle pulse: write dropped
req0_valid  in  1  requester 0 has a block
req0_data  in  128  requester 0 plaintext
req0_ready  out  1  requester 0 block accepted this cycle
req1_valid  in  1  requester 1 has a block
req1_data  in  128  requester 1 plaintext
req1_ready  out  1  requester 1 block accepted this cycle
rsp_valid  out  1  one-cycle result pulse
rsp_id  out  1  owner of rsp_data
rsp_data  out  128  ciphertext
err_timeout  out  1  one-cycle pulse: block abandoned
in_en  out  1  to core: start pulse
in_data  out  128  to core: plaintext
key_round  out  128  to core: current round key
key_ready  in  1  from core: advance to next round key
out_en  in  1  from core: result valid
out_data  in  128  from core: ciphertext

Behaviour:
- Reset (kill high, async): all outputs 0 and key_round = 0. Table valid mask cleared, state IDLE, last_grant = 1, key index = 1. Table contents are not reset.
- Key table:
  - Write at posedge when key_wr_en is high, state is IDLE and addr <= 10. The write also sets the valid bit for that entry.
  - A write with addr > 10, or in any state other than IDLE, is dropped. key_wr_err pulses the next cycle.
  - keys_loaded = all 11 valid bits set.
  - In IDLE, key_round is registered equal to table[0], so it follows a rewrite of entry 0 one cycle later.
- States: IDLE, RUN, RESP.
- IDLE:
  - Acceptance requires keys_loaded and at least one valid request.
  - Grant goes to the single valid requester. If both are valid, grant goes to the one that is not last_grant.
  - reqN_ready is combinational and high only on the acceptance cycle T.
  - On T: latch data and id, update last_grant, key index = 1.
  - At T+1: in_en = 1 for exactly one cycle, in_data = latched data, key_round = table[0]. Enter RUN.
  - After reset, with both requesters valid, req0 is granted first.
- RUN:
  - Each posedge with key_ready high: key_round <= table[index], index++.
  - The index saturates at 10. Further key_ready pulses re-present table[10].
  - The timeout counter starts at 0 on the in_en cycle and counts every cycle.
  - out_en high: capture out_data, go to RESP.
  - Counter reaches TIMEOUT-1 without out_en: err_timeout pulses the next cycle, no rsp is produced, return to IDLE.
  - out_en on the same cycle as the timeout: out_en wins.
- RESP (1 cycle): rsp_valid = 1, rsp_id = latched id, rsp_data = captured data. Return to IDLE with key_round = table[0] and index = 1.
  - The earliest next acceptance is therefore the first IDLE cycle; no back-to-back overlap.
- out_en or key_ready seen in IDLE or RESP is ignored.
- in_data returns to 0 after the in_en cycle.
- A requester that drops valid before acceptance simply loses its turn; no state is kept for it.
- kill high mid-RUN aborts the block: no rsp, no error pulse.

Decomposition:
- Shared package aes_128_pkg:
  - AES_NKEYS = 11, AES_BLK_W = 128, AES_KIDX_W = 4
  - state encoding IDLE/RUN/RESP
- Sub-module aes_128_key_table: 11x128 register file. It has a write port, the valid mask, keys_loaded, and a combinational read port.

Test Plan:
1. Load FIPS-197 keys in core byte order:
   - table[0] = 0f0e0d0c0b0a09080706050403020100
   - table[1] = fe76abd6f178a6dafa72afd2fd74aad6
   - ...
   - table[10] = c5302b4d8ba707f3174a94e37f1d1113
   Then req0 sends ffeeddccbbaa99887766554433221100.
   -> req0_ready at T, in_en at T+1, key_round steps through table[1..10] one per key_ready, rsp_valid with rsp_id = 0 and rsp_data = 5ac5b47080b7cdd830047b6ad8e0c469.
2. req0 and req1 both valid continuously for 3 blocks -> grant order 0, 1, 0, and the rsp_id sequence matches.
3. Only 10 of 11 keys loaded, req0 valid -> req0_ready stays 0 and no in_en. Write the 11th key -> accepted on the next cycle.
4. Key write during RUN, and a write with addr = 12 -> key_wr_err pulses once per write, table unchanged, the result is still correct.
5. Core stub never asserts out_en, TIMEOUT = 64 -> err_timeout 64 cycles after in_en, no rsp_valid, the next request is accepted.
6. Assert kill for 2 cycles mid-RUN, then reapply the same block -> all outputs 0 during reset, the valid mask is cleared (keys must be reloaded), and the rerun yields the ciphertext from scenario 1.
